// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit(s), each bit paced by baud_tick.
// Start bit begins one clock after the first tick following the handshake; tx_ready holds off upstream until the frame ends.
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 parity_bit;

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign baud_en  = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            shift      <= tx_data;
            bit_cnt    <= '0;
            // Parity is captured up front because the shift register is consumed bit by bit.
            parity_bit <= (^tx_data) ^ PARITY_ODD;
            state      <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (baud_tick) begin
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state <= ST_DATA;
            tx    <= shift[0];
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift <= shift >> 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_EN) begin
                state <= ST_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (baud_tick) begin
            if (bit_cnt == LAST_STOP) begin
              state   <= ST_IDLE;
              tx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three parameterisations (8N1, 8E2, 8O1) against a bit-list reference model.
module tb_uart_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data;
  logic [2:0] tx_valid, tx_ready, baud_tick, baud_en, tx, busy, tx_done;

  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .baud_tick(baud_tick[0]), .baud_en(baud_en[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .baud_tick(baud_tick[1]), .baud_en(baud_en[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .baud_tick(baud_tick[2]), .baud_en(baud_en[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));

  int cfg_par[3]  = '{0, 1, 1};
  int cfg_odd[3]  = '{0, 0, 1};
  int cfg_stop[3] = '{1, 2, 1};

  // Reference model: a frame is a list of line levels, one popped per tick.
  bit          m_active[3];
  bit          m_tx[3];
  bit          m_done[3];
  logic [11:0] m_frame[3];
  int          m_left[3];

  int gen_cnt[3];
  int first[3];
  bit rand_mode;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [7:0]  data;
    int          first;
    int          nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    int pos;
    m_done[i] = 1'b0;
    if (rst) begin
      m_active[i] = 1'b0;
      m_left[i]   = 0;
      m_tx[i]     = 1'b1;
    end else if (m_active[i]) begin
      if (baud_tick[i]) begin
        if (m_left[i] > 0) begin
          m_tx[i]    = m_frame[i][0];
          m_frame[i] = m_frame[i] >> 1;
          m_left[i]--;
        end else begin
          m_done[i]   = 1'b1;
          m_active[i] = 1'b0;
          m_tx[i]     = 1'b1;
        end
      end
    end else if (tx_valid[i]) begin
      m_active[i] = 1'b1;
      m_tx[i]     = 1'b1;
      m_frame[i]  = {3'b000, tx_data, 1'b0};
      pos = 9;
      if (cfg_par[i] != 0) begin
        m_frame[i][pos] = (^tx_data) ^ cfg_odd[i][0];
        pos++;
      end
      for (int s = 0; s < cfg_stop[i]; s++) m_frame[i][pos + s] = 1'b1;
      m_left[i] = pos + cfg_stop[i];
    end
  endtask

  task automatic gen_tick(input int i);
    if (rand_mode) begin
      baud_tick[i] = !baud_tick[i] && ($urandom_range(0, 3) == 0);
    end else begin
      if (baud_en[i] === 1'b1) gen_cnt[i]++;
      else gen_cnt[i] = 0;
      baud_tick[i] = (baud_en[i] === 1'b1) && (gen_cnt[i] >= first[i]) &&
                     (((gen_cnt[i] - first[i]) % 8) == 0);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("tx", i, tx[i], m_tx[i]);
      check("tx_done", i, tx_done[i], m_done[i]);
      check("tx_ready", i, tx_ready[i], !m_active[i]);
      check("busy", i, busy[i], m_active[i]);
      check("baud_en", i, baud_en[i], m_active[i]);
      gen_tick(i);
    end
  endtask

  task automatic wait_ready(input int i);
    int g = 0;
    while (tx_ready[i] !== 1'b1 && g < 300) begin
      tick_cycle();
      g++;
    end
    check("ready_wait", i, tx_ready[i], 1);
  endtask

  task automatic wait_start(input int i, output int hi);
    hi = 0;
    while (tx[i] === 1'b1 && hi < 200) begin
      hi++;
      tick_cycle();
    end
  endtask

  task automatic check_frame(input int i, input logic [11:0] bits, input int nbits);
    logic [7:0] samp;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < 8; c++) begin
        samp[c] = tx[i];
        tick_cycle();
      end
      check("frame_bit", i, samp, {8{bits[k]}});
    end
    check("done_pulse", i, tx_done[i], 1);
    check("ready_after_done", i, tx_ready[i], 1);
    tick_cycle();
    check("done_single", i, tx_done[i], 0);
  endtask

  task automatic run_frame(input vec_t v);
    int hi;
    first[v.inst]    = v.first;
    tx_data          = v.data;
    tx_valid[v.inst] = 1'b1;
    wait_ready(v.inst);
    tick_cycle();
    tx_valid[v.inst] = 1'b0;
    tx_data          = 8'($urandom);
    wait_start(v.inst, hi);
    check("sync_len", v.inst, hi, v.first);
    check_frame(v.inst, v.bits, v.nbits);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi;
    vec_t v;
    rst       = 1'b1;
    tx_valid  = '0;
    baud_tick = '0;
    tx_data   = '0;
    rand_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      first[i]    = 7;
      gen_cnt[i]  = 0;
      m_active[i] = 1'b0;
      m_tx[i]     = 1'b1;
      m_done[i]   = 1'b0;
      m_left[i]   = 0;
      m_frame[i]  = '0;
    end

    // {inst, data, first-tick delay, bit count, line levels LSB = first bit}
    tbl[0] = '{0, 8'hA5, 7, 10, 12'h34A};
    tbl[1] = '{1, 8'hA5, 7, 12, 12'hD4A};
    tbl[2] = '{2, 8'hA5, 7, 11, 12'h74A};
    tbl[3] = '{1, 8'h07, 7, 12, 12'hE0E};
    tbl[4] = '{0, 8'h3C, 1, 10, 12'h278};
    tbl[5] = '{2, 8'h07, 4, 11, 12'h40E};

    tick_cycle();
    tick_cycle();
    for (int i = 0; i < 3; i++) begin
      check("rst_tx", i, tx[i], 1);
      check("rst_ready", i, tx_ready[i], 1);
      check("rst_busy", i, busy[i], 0);
      check("rst_baud_en", i, baud_en[i], 0);
      check("rst_done", i, tx_done[i], 0);
    end
    rst = 1'b0;
    repeat (20) begin
      tick_cycle();
      check("idle_tx", 0, tx[0], 1);
      check("idle_baud_en", 0, baud_en[0], 0);
    end

    for (int n = 0; n < 6; n++) run_frame(tbl[n]);

    // Back-to-back with tx_valid held: one idle bit period between frames.
    first[0]    = 7;
    tx_data     = 8'h00;
    tx_valid[0] = 1'b1;
    wait_ready(0);
    tick_cycle();
    tx_data = 8'hFF;
    wait_start(0, hi);
    check("b2b_sync", 0, hi, 7);
    check_frame(0, 12'h200, 10);
    check("b2b_accept", 0, busy[0], 1);
    tx_valid[0] = 1'b0;
    wait_start(0, hi);
    check("b2b_gap", 0, 1 + hi, 8);
    check_frame(0, 12'h3FE, 10);

    // Reset wins over a simultaneous handshake.
    rst         = 1'b1;
    tx_valid[0] = 1'b1;
    tick_cycle();
    check("rst_over_hs", 0, busy[0], 0);
    rst         = 1'b0;
    tx_valid[0] = 1'b0;
    tick_cycle();

    // Reset during data bit 3 abandons the frame.
    first[0]    = 7;
    tx_data     = 8'h3C;
    tx_valid[0] = 1'b1;
    wait_ready(0);
    tick_cycle();
    tx_valid[0] = 1'b0;
    wait_start(0, hi);
    repeat (35) tick_cycle();
    rst = 1'b1;
    tick_cycle();
    check("midrst_tx", 0, tx[0], 1);
    check("midrst_baud_en", 0, baud_en[0], 0);
    check("midrst_busy", 0, busy[0], 0);
    check("midrst_done", 0, tx_done[0], 0);
    rst = 1'b0;
    repeat (30) begin
      tick_cycle();
      check("midrst_no_done", 0, tx_done[0], 0);
    end
    v = '{0, 8'h55, 7, 10, 12'h2AA};
    run_frame(v);

    // Random traffic, ticks (including in IDLE) and occasional resets.
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) tx_valid[i] = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      rst     = ($urandom_range(0, 299) == 0);
      tick_cycle();
    end
    rst       = 1'b1;
    tx_valid  = '0;
    tick_cycle();
    rand_mode = 1'b0;
    baud_tick = '0;
    rst       = 1'b0;
    repeat (5) tick_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
